// File: rtl/csr_trap_unit_pkg.sv
// Package csr_pkg: shared constants for the machine-mode CSR file and trap
// controller.
// Contents:
//   - CSR addresses
//   - Zicsr operation encodings and the read/modify/write helper
//   - mstatus and mip bit positions
//   - interrupt and exception cause codes
//   - the misa value
package csr_pkg;

    // Machine CSR addresses
    localparam logic [11:0] CSR_MSTATUS       = 12'h300;
    localparam logic [11:0] CSR_MISA          = 12'h301;
    localparam logic [11:0] CSR_MIE           = 12'h304;
    localparam logic [11:0] CSR_MTVEC         = 12'h305;
    localparam logic [11:0] CSR_MCOUNTINHIBIT = 12'h320;
    localparam logic [11:0] CSR_MSCRATCH      = 12'h340;
    localparam logic [11:0] CSR_MEPC          = 12'h341;
    localparam logic [11:0] CSR_MCAUSE        = 12'h342;
    localparam logic [11:0] CSR_MTVAL         = 12'h343;
    localparam logic [11:0] CSR_MIP           = 12'h344;
    localparam logic [11:0] CSR_MCYCLE        = 12'hB00;
    localparam logic [11:0] CSR_MINSTRET      = 12'hB02;
    localparam logic [11:0] CSR_MCYCLEH       = 12'hB80;
    localparam logic [11:0] CSR_MINSTRETH     = 12'hB82;
    localparam logic [11:0] CSR_MVENDORID     = 12'hF11;
    localparam logic [11:0] CSR_MARCHID       = 12'hF12;
    localparam logic [11:0] CSR_MIMPID        = 12'hF13;
    localparam logic [11:0] CSR_MHARTID       = 12'hF14;

    // csr_op[1:0]; csr_op[2] selects the immediate source
    typedef enum logic [1:0] {
        CSR_OP_NONE = 2'b00,
        CSR_OP_RW   = 2'b01,
        CSR_OP_RS   = 2'b10,
        CSR_OP_RC   = 2'b11
    } csr_op_e;

    // mstatus bits
    localparam int MSTATUS_MIE  = 3;
    localparam int MSTATUS_MPIE = 7;

    // mip / mie bits
    localparam int MIP_MSI   = 3;
    localparam int MIP_MTI   = 7;
    localparam int MIP_MEI   = 11;
    localparam int MIP_LIRQ0 = 16;

    // Interrupt cause codes
    localparam logic [4:0] CAUSE_MSI   = 5'd3;
    localparam logic [4:0] CAUSE_MTI   = 5'd7;
    localparam logic [4:0] CAUSE_MEI   = 5'd11;
    localparam logic [4:0] CAUSE_LIRQ0 = 5'd16;

    // Exception cause codes
    localparam logic [4:0] EXC_INSN_MISALIGN  = 5'd0;
    localparam logic [4:0] EXC_ILLEGAL_INSN   = 5'd2;
    localparam logic [4:0] EXC_BREAKPOINT     = 5'd3;
    localparam logic [4:0] EXC_LOAD_MISALIGN  = 5'd4;
    localparam logic [4:0] EXC_STORE_MISALIGN = 5'd6;
    localparam logic [4:0] EXC_ECALL_M        = 5'd11;

    // RV32I, MXL=1
    localparam logic [31:0] MISA_VAL = 32'h4000_0100;

    // New CSR value for a Zicsr read/modify/write
    function automatic logic [31:0] csr_modify(input csr_op_e op,
                                               input logic [31:0] old,
                                               input logic [31:0] src);
        case (op)
            CSR_OP_RW: csr_modify = src;
            CSR_OP_RS: csr_modify = old | src;
            CSR_OP_RC: csr_modify = old & ~src;
            default:   csr_modify = old;
        endcase
    endfunction

endpackage

// File: rtl/csr_trap_unit_if.sv
// CSR access bus between EX (master) and the CSR file (slave).
//
// Signals:
//   csr_valid   - access this cycle
//   csr_adr     - 12-bit CSR address
//   csr_op      - [2] immediate, [1:0] rw/rs/rc
//   csr_uimm    - zero-extended immediate source
//   csr_rs1     - register source
//   csr_rdata   - old CSR value, combinational from csr_adr
//   csr_illegal - access is illegal; qualified by csr_valid
//
// Handshake: valid-only, with an implicit ready that is always 1.
//   - A cycle with csr_valid high is one complete access.
//   - csr_rdata and csr_illegal are valid combinationally in that same cycle.
//   - The write, if legal, commits at the closing clock edge.
interface csr_trap_unit_if;
    logic        csr_valid;
    logic [11:0] csr_adr;
    logic [2:0]  csr_op;
    logic [4:0]  csr_uimm;
    logic [31:0] csr_rs1;
    logic [31:0] csr_rdata;
    logic        csr_illegal;

    modport master (
        output csr_valid, csr_adr, csr_op, csr_uimm, csr_rs1,
        input  csr_rdata, csr_illegal
    );

    modport slave (
        input  csr_valid, csr_adr, csr_op, csr_uimm, csr_rs1,
        output csr_rdata, csr_illegal
    );
endinterface

// File: rtl/csr_trap_unit_counter.sv
// csr_counter: CNT_W-bit event counter that is visible as two 32-bit CSR
// halves.
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   inhibit        - freeze counting (mcountinhibit bit)
//   inc            - count this cycle
//   wr_lo, wr_hi   - replace the low or high half with wdata
//   wdata          - write data
//   rd_lo, rd_hi   - 32-bit halves; rd_hi bits at or above CNT_W read 0
// Behaviour:
//   - A write to either half suppresses that cycle's increment.
//   - The counter wraps to 0 at 2^CNT_W.
module csr_counter #(
    parameter int CNT_W = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        inhibit,
    input  logic        inc,
    input  logic        wr_lo,
    input  logic        wr_hi,
    input  logic [31:0] wdata,
    output logic [31:0] rd_lo,
    output logic [31:0] rd_hi
);
    localparam int HI_W = CNT_W - 32;

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (wr_lo || wr_hi) begin
            if (wr_lo) cnt_d[31:0] = wdata;
            if (wr_hi) cnt_d[CNT_W-1:32] = wdata[HI_W-1:0];
        end else if (inc && !inhibit) begin
            cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    always_comb begin
        rd_lo = cnt_q[31:0];
        rd_hi = '0;
        rd_hi[HI_W-1:0] = cnt_q[CNT_W-1:32];
    end
endmodule

// File: rtl/csr_trap_unit.sv
// csr_trap_unit: machine-mode CSR file and trap controller beside EX.
//
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   csr             - CSR access bus (slave modport)
//   inst_retire     - an instruction retired this cycle
//   trap_req        - synchronous exception request
//   trap_cause      - exception code
//   trap_pc         - faulting PC[31:2]
//   trap_tval       - mtval value for the exception
//   mret            - mret executing
//   ext_irq, tmr_irq, sw_irq, lirq - level interrupt sources
//   irq_accept      - pipeline can take an interrupt this cycle
//   irq_pc          - resume PC[31:2] for an interrupt
//   irq_pending     - mstatus.MIE & |(mip & mie)
//   trap_take       - redirect this cycle (trap entry or mret)
//   trap_vec        - redirect target PC[31:2]
module csr_trap_unit
    import csr_pkg::*;
#(
    parameter int          NUM_LIRQ  = 4,
    parameter int          CNT_W     = 64,
    parameter logic [31:0] MTVEC_RST = 32'h0000_0000,
    parameter int          HART_ID   = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    csr_trap_unit_if.slave      csr,
    input  logic                inst_retire,
    input  logic                trap_req,
    input  logic [4:0]          trap_cause,
    input  logic [29:0]         trap_pc,
    input  logic [31:0]         trap_tval,
    input  logic                mret,
    input  logic                ext_irq,
    input  logic                tmr_irq,
    input  logic                sw_irq,
    input  logic [NUM_LIRQ-1:0] lirq,
    input  logic                irq_accept,
    input  logic [29:0]         irq_pc,
    output logic                irq_pending,
    output logic                trap_take,
    output logic [29:0]         trap_vec
);
    localparam logic [31:0] LIRQ_MASK = 32'(((64'd1 << NUM_LIRQ) - 64'd1) << MIP_LIRQ0);
    localparam logic [31:0] MIE_MASK  = LIRQ_MASK | 32'h0000_0888;

    // Architectural state
    logic        st_mie, st_mpie;
    logic [31:0] mie_q, mtvec_q, mscratch_q, mcause_q, mtval_q;
    logic [29:0] mepc_q;
    logic        inh_cy, inh_ir;

    // Access decode
    logic [11:0] adr;
    logic [31:0] mstatus_w, mip_w, rdata, src, wdata;
    logic        implemented, read_only, illegal, wr_en;
    logic [31:0] cyc_lo, cyc_hi, ins_lo, ins_hi;
    csr_op_e     op;

    // Trap arbitration
    logic [31:0] pend;
    logic [4:0]  irq_cause;
    logic        take_exc, take_irq, take_mret;

    assign adr = csr.csr_adr;
    assign op  = csr_op_e'(csr.csr_op[1:0]);

    always_comb begin
        mstatus_w = 32'h0000_1800;  // MPP is hardwired to M
        mstatus_w[MSTATUS_MIE]  = st_mie;
        mstatus_w[MSTATUS_MPIE] = st_mpie;
        mip_w = '0;
        mip_w[MIP_MSI] = sw_irq;
        mip_w[MIP_MTI] = tmr_irq;
        mip_w[MIP_MEI] = ext_irq;
        mip_w[MIP_LIRQ0 +: NUM_LIRQ] = lirq;
    end

    // Read mux; also classifies the address
    always_comb begin
        rdata       = '0;
        implemented = 1'b1;
        read_only   = 1'b0;
        case (adr)
            CSR_MSTATUS:       rdata = mstatus_w;
            CSR_MISA:          rdata = MISA_VAL;
            CSR_MIE:           rdata = mie_q;
            CSR_MTVEC:         rdata = mtvec_q;
            CSR_MCOUNTINHIBIT: rdata = {29'b0, inh_ir, 1'b0, inh_cy};
            CSR_MSCRATCH:      rdata = mscratch_q;
            CSR_MEPC:          rdata = {mepc_q, 2'b00};
            CSR_MCAUSE:        rdata = mcause_q;
            CSR_MTVAL:         rdata = mtval_q;
            CSR_MIP:           rdata = mip_w;
            CSR_MCYCLE:        rdata = cyc_lo;
            CSR_MCYCLEH:       rdata = cyc_hi;
            CSR_MINSTRET:      rdata = ins_lo;
            CSR_MINSTRETH:     rdata = ins_hi;
            CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: read_only = 1'b1;
            CSR_MHARTID: begin
                rdata     = 32'(HART_ID);
                read_only = 1'b1;
            end
            default:           implemented = 1'b0;
        endcase
    end

    // misa and mip are not flagged: writes to them are silently dropped
    assign illegal = csr.csr_valid && (!implemented || (read_only && op == CSR_OP_RW));
    assign wr_en   = csr.csr_valid && !illegal && op != CSR_OP_NONE;
    assign src     = csr.csr_op[2] ? {27'b0, csr.csr_uimm} : csr.csr_rs1;
    assign wdata   = csr_modify(op, rdata, src);

    assign csr.csr_rdata   = rdata;
    assign csr.csr_illegal = illegal;

    // Interrupt priority: MEI > MSI > MTI > lirq[0] > lirq[1] > ...
    always_comb begin
        pend      = mip_w & mie_q;
        irq_cause = '0;
        if (pend[MIP_MEI])      irq_cause = CAUSE_MEI;
        else if (pend[MIP_MSI]) irq_cause = CAUSE_MSI;
        else if (pend[MIP_MTI]) irq_cause = CAUSE_MTI;
        else begin
            // Descending scan so the lowest-numbered line wins
            for (int i = NUM_LIRQ - 1; i >= 0; i--) begin
                if (pend[MIP_LIRQ0 + i]) irq_cause = CAUSE_LIRQ0 + 5'(i);
            end
        end
    end

    assign irq_pending = st_mie && (|pend);
    assign take_exc    = trap_req;
    assign take_irq    = !trap_req && irq_pending && irq_accept;
    assign take_mret   = !trap_req && !(irq_pending && irq_accept) && mret;
    assign trap_take   = trap_req || mret || (irq_pending && irq_accept);

    always_comb begin
        trap_vec = '0;
        if (take_exc) begin
            trap_vec = mtvec_q[31:2];
        end else if (take_irq) begin
            // Only interrupts are vectored; exceptions always use the base
            trap_vec = mtvec_q[31:2] + (mtvec_q[0] ? {25'b0, irq_cause} : 30'd0);
        end else if (take_mret) begin
            trap_vec = mepc_q;
        end
    end

    // Trap entry and mret own the CSRs they update; CSR writes to those
    // CSRs in the same cycle are dropped, all other writes commit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_mie     <= 1'b0;
            st_mpie    <= 1'b0;
            mie_q      <= '0;
            mtvec_q    <= MTVEC_RST;
            mscratch_q <= '0;
            mepc_q     <= '0;
            mcause_q   <= '0;
            mtval_q    <= '0;
            inh_cy     <= 1'b0;
            inh_ir     <= 1'b0;
        end else begin
            if (wr_en && adr == CSR_MIE)      mie_q <= wdata & MIE_MASK;
            if (wr_en && adr == CSR_MTVEC)    mtvec_q <= wdata[1] ? {wdata[31:2], 2'b00} : wdata;
            if (wr_en && adr == CSR_MSCRATCH) mscratch_q <= wdata;
            if (wr_en && adr == CSR_MCOUNTINHIBIT) begin
                inh_cy <= wdata[0];
                inh_ir <= wdata[2];
            end
            if (take_exc || take_irq) begin
                mepc_q   <= take_exc ? trap_pc : irq_pc;
                mcause_q <= {take_irq, 26'b0, take_exc ? trap_cause : irq_cause};
                mtval_q  <= take_exc ? trap_tval : 32'b0;
                st_mpie  <= st_mie;
                st_mie   <= 1'b0;
            end else begin
                if (wr_en && adr == CSR_MEPC)   mepc_q   <= wdata[31:2];
                if (wr_en && adr == CSR_MCAUSE) mcause_q <= wdata;
                if (wr_en && adr == CSR_MTVAL)  mtval_q  <= wdata;
                if (take_mret) begin
                    st_mie  <= st_mpie;
                    st_mpie <= 1'b1;
                end else if (wr_en && adr == CSR_MSTATUS) begin
                    st_mie  <= wdata[MSTATUS_MIE];
                    st_mpie <= wdata[MSTATUS_MPIE];
                end
            end
        end
    end

    csr_counter #(.CNT_W(CNT_W)) u_mcycle (
        .clk     (clk),
        .rst_n   (rst_n),
        .inhibit (inh_cy),
        .inc     (1'b1),
        .wr_lo   (wr_en && adr == CSR_MCYCLE),
        .wr_hi   (wr_en && adr == CSR_MCYCLEH),
        .wdata   (wdata),
        .rd_lo   (cyc_lo),
        .rd_hi   (cyc_hi)
    );

    csr_counter #(.CNT_W(CNT_W)) u_minstret (
        .clk     (clk),
        .rst_n   (rst_n),
        .inhibit (inh_ir),
        .inc     (inst_retire),
        .wr_lo   (wr_en && adr == CSR_MINSTRET),
        .wr_hi   (wr_en && adr == CSR_MINSTRETH),
        .wdata   (wdata),
        .rd_lo   (ins_lo),
        .rd_hi   (ins_hi)
    );
endmodule
